// File: rtl/noc_pkg.sv
// noc_pkg: shared NOC-side types and sizing for the ifmap staging path.
package noc_pkg;
  localparam int MEM_BATCH_LINES = 35;
  localparam int IFMAP_LINE_BYTES = 256;
  typedef enum logic [1:0] {EMPTY, FILL, FULL} BUF_STATE;
  typedef logic [IFMAP_LINE_BYTES*8-1:0] IFMAP_LINE;
endpackage

// File: rtl/ifmap_batch_buffer_if.sv
// ifmap_batch_buffer_if: line write port from the read engine plus batch port to the NOC.
// IFMAP_BUF_STATS_EN adds the stall/batch statistics outputs.
interface ifmap_batch_buffer_if #(
  parameter int BATCH_LINES = noc_pkg::MEM_BATCH_LINES,
  parameter int LINE_BYTES = noc_pkg::IFMAP_LINE_BYTES
);
  localparam int LW = LINE_BYTES*8;
  logic start;
  logic wr_valid;
  logic wr_ready;
  logic [LW-1:0] wr_data;
  logic wr_last;
  logic [BATCH_LINES*LW-1:0] ifmap_data_out;
  logic ifmap_data_valid;
  logic free_ifmap_buffer;
  logic free_err;
  logic fill_bank;
`ifdef IFMAP_BUF_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] batches_done;
`endif
  modport slave (
    input start, wr_valid, wr_data, wr_last, free_ifmap_buffer,
    output wr_ready, ifmap_data_out, ifmap_data_valid, free_err, fill_bank
`ifdef IFMAP_BUF_STATS_EN
    , output stall_cycles, batches_done
`endif
  );
  modport master (
    output start, wr_valid, wr_data, wr_last, free_ifmap_buffer,
    input wr_ready, ifmap_data_out, ifmap_data_valid, free_err, fill_bank
`ifdef IFMAP_BUF_STATS_EN
    , input stall_cycles, batches_done
`endif
  );
endinterface

// File: rtl/ifmap_batch_buffer_bank.sv
// ifmap_bank: one batch bank with storage, written-line mask, state and masked read mux.
module ifmap_bank
  import noc_pkg::*;
#(
  parameter int BATCH_LINES = MEM_BATCH_LINES,
  parameter int LINE_BYTES = IFMAP_LINE_BYTES,
  localparam int LW = LINE_BYTES*8,
  localparam int LCNT_W = $clog2(BATCH_LINES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic wr_en_i,
  input  logic close_i,
  input  logic release_i,
  input  logic [LCNT_W-1:0] wr_idx_i,
  input  logic [LW-1:0] wr_data_i,
  output BUF_STATE state_o,
  output logic [BATCH_LINES*LW-1:0] rd_data_o
);
  logic [LW-1:0] mem_q [BATCH_LINES];
  logic [BATCH_LINES-1:0] mask_q, mask_d, sel;
  BUF_STATE state_q, state_d;
  assign sel = BATCH_LINES'(1) << wr_idx_i;
  assign state_o = state_q;
  // Opening a fill wipes the mask so stale lines from the previous batch read as zero.
  always_comb begin
    mask_d = mask_q;
    state_d = state_q;
    if (clr_i) begin
      mask_d = '0;
      state_d = EMPTY;
    end else begin
      if (wr_en_i) begin
        mask_d = (state_q == EMPTY) ? sel : (mask_q | sel);
        state_d = close_i ? FULL : FILL;
      end
      if (release_i) state_d = EMPTY;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      state_q <= EMPTY;
    end else begin
      mask_q <= mask_d;
      state_q <= state_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BATCH_LINES; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end
  for (genvar g = 0; g < BATCH_LINES; g++) begin : g_rd
    assign rd_data_o[g*LW +: LW] = mask_q[g] ? mem_q[g] : '0;
  end
endmodule

// File: rtl/ifmap_batch_buffer.sv
// ifmap_batch_buffer: ping-pong batch assembler between the memory read engine and the NOC.
// IFMAP_BUF_STATS_EN adds saturating stall_cycles / batches_done counters.
module ifmap_batch_buffer
  import noc_pkg::*;
#(
  parameter int BATCH_LINES = MEM_BATCH_LINES,
  parameter int LINE_BYTES = IFMAP_LINE_BYTES,
  localparam int LW = LINE_BYTES*8,
  localparam int LCNT_W = $clog2(BATCH_LINES)
) (
  input logic clk,
  input logic rst,
  ifmap_batch_buffer_if.slave bus
);
  BUF_STATE st [2];
  logic [BATCH_LINES*LW-1:0] rd [2];
  logic wbank_q, wbank_d, rbank_q, rbank_d, free_err_q, free_err_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic accept, close, rel;
  assign bus.wr_ready = st[wbank_q] != FULL;
  assign bus.ifmap_data_valid = st[rbank_q] == FULL;
  assign bus.ifmap_data_out = rd[rbank_q];
  assign bus.free_err = free_err_q;
  assign bus.fill_bank = wbank_q;
  // start takes priority: a write or free in the start cycle is dropped.
  assign accept = bus.wr_valid && bus.wr_ready && !bus.start;
  assign close = accept && (bus.wr_last || line_cnt_q == LCNT_W'(BATCH_LINES-1));
  assign rel = bus.free_ifmap_buffer && bus.ifmap_data_valid && !bus.start;
  always_comb begin
    wbank_d = bus.start ? 1'b0 : wbank_q ^ close;
    rbank_d = bus.start ? 1'b0 : rbank_q ^ rel;
    line_cnt_d = (bus.start || close) ? '0 : accept ? line_cnt_q + LCNT_W'(1) : line_cnt_q;
    free_err_d = !bus.start && (free_err_q || (bus.free_ifmap_buffer && !bus.ifmap_data_valid));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      line_cnt_q <= '0;
      free_err_q <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      line_cnt_q <= line_cnt_d;
      free_err_q <= free_err_d;
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ifmap_bank #(.BATCH_LINES(BATCH_LINES), .LINE_BYTES(LINE_BYTES)) u_bank (
      .clk(clk),
      .rst(rst),
      .clr_i(bus.start),
      .wr_en_i(accept && wbank_q == 1'(b)),
      .close_i(close),
      .release_i(rel && rbank_q == 1'(b)),
      .wr_idx_i(line_cnt_q),
      .wr_data_i(bus.wr_data),
      .state_o(st[b]),
      .rd_data_o(rd[b])
    );
  end
`ifdef IFMAP_BUF_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] done_q, done_d;
  assign bus.stall_cycles = stall_q;
  assign bus.batches_done = done_q;
  always_comb begin
    stall_d = bus.start ? '0 : (bus.wr_valid && !bus.wr_ready && ~&stall_q) ? stall_q + 32'd1 : stall_q;
    done_d = bus.start ? '0 : (rel && ~&done_q) ? done_q + 16'd1 : done_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      done_q <= '0;
    end else begin
      stall_q <= stall_d;
      done_q <= done_d;
    end
  end
`endif
endmodule

// File: tb/tb_ifmap_batch_buffer.sv
// tb_ifmap_batch_buffer: directed stimulus with a batch scoreboard checked by a separate monitor.
module tb_ifmap_batch_buffer;
  import noc_pkg::*;
  localparam int BL = MEM_BATCH_LINES;
  localparam int LW = IFMAP_LINE_BYTES*8;
  typedef logic [BL*LW-1:0] batch_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ifmap_batch_buffer_if bif ();
  ifmap_batch_buffer dut (.clk(clk), .rst(rst), .bus(bif));
  int tests = 0, fails = 0, pops = 0;
  batch_t exp_q[$];
  batch_t e;
  int bad;
  logic pv = 1'b0, took = 1'b0;

  function automatic logic [LW-1:0] pat(input int v);
    return {IFMAP_LINE_BYTES{8'(v)}};
  endfunction

  function automatic batch_t mk(input int base, input int n);
    batch_t b = '0;
    for (int i = 0; i < n; i++) b[i*LW +: LW] = pat(base + i);
    return b;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_line(input string nm, input int idx, input logic [LW-1:0] exp);
    logic [LW-1:0] act;
    act = bif.ifmap_data_out[idx*LW +: LW];
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: line %0d low bits got %h expected %h", nm, idx, act[63:0], exp[63:0]);
    end
  endtask

  task automatic send(input int v, input bit last);
    int t = 0;
    bif.wr_valid = 1'b1;
    bif.wr_data = pat(v);
    bif.wr_last = last;
    while (!bif.wr_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: wr_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    bif.wr_valid = 1'b0;
    bif.wr_last = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) send(base + i, last_at_end && i == n - 1);
  endtask

  task automatic pulse_free();
    bif.free_ifmap_buffer = 1'b1;
    @(posedge clk);
    #1;
    bif.free_ifmap_buffer = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A new batch is presented when valid rises or a free was accepted while the other bank was full.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      took = 1'b0;
    end else begin
      if (bif.ifmap_data_valid && (!pv || took)) begin
        tests++;
        pops++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL batch_pop: got unexpected batch expected none");
        end else begin
          e = exp_q.pop_front();
          if (bif.ifmap_data_out !== e) begin
            fails++;
            bad = 0;
            for (int i = BL - 1; i >= 0; i--)
              if (bif.ifmap_data_out[i*LW +: LW] !== e[i*LW +: LW]) bad = i;
            $display("FAIL batch_data: line %0d got %h expected %h", bad,
                     bif.ifmap_data_out[bad*LW +: 32], e[bad*LW +: 32]);
          end
        end
      end
      took = bif.free_ifmap_buffer && bif.ifmap_data_valid;
      pv = bif.ifmap_data_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bif.start = 1'b0;
    bif.wr_valid = 1'b0;
    bif.wr_data = '0;
    bif.wr_last = 1'b0;
    bif.free_ifmap_buffer = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_wr_ready", bif.wr_ready, 1);
    check("rst_valid", bif.ifmap_data_valid, 0);
    check("rst_free_err", bif.free_err, 0);
    check("rst_fill_bank", bif.fill_bank, 0);
    // full batch into bank 0
    stream(0, 34, 0);
    check("t1_pre_valid", bif.ifmap_data_valid, 0);
    exp_q.push_back(mk(0, 35));
    send(34, 0);
    check("t1_valid", bif.ifmap_data_valid, 1);
    check_line("t1_line7", 7, pat(7));
    check("t1_fill_bank", bif.fill_bank, 1);
    // both banks full, then free
    exp_q.push_back(mk(35, 35));
    stream(35, 35, 0);
    check("t2_wr_ready_full", bif.wr_ready, 0);
    check("t2_fill_bank", bif.fill_bank, 0);
    pulse_free();
    check("t2_valid", bif.ifmap_data_valid, 1);
    check_line("t2_line0", 0, pat(35));
    check("t2_wr_ready", bif.wr_ready, 1);
    // short batch via wr_last into bank 0 which still holds stale lines
    exp_q.push_back(mk(160, 12));
    stream(160, 12, 1);
    check("t3_wr_ready_full", bif.wr_ready, 0);
    pulse_free();
    check("t3_valid", bif.ifmap_data_valid, 1);
    check_line("t3_line11", 11, pat(171));
    check_line("t3_line12", 12, '0);
    check_line("t3_line34", 34, '0);
    check("t3_wr_ready", bif.wr_ready, 1);
    // close of bank 1 in the same cycle as free of bank 0
    exp_q.push_back(mk(80, 35));
    stream(80, 34, 0);
    bif.wr_valid = 1'b1;
    bif.wr_data = pat(114);
    bif.free_ifmap_buffer = 1'b1;
    @(posedge clk);
    #1;
    bif.wr_valid = 1'b0;
    bif.free_ifmap_buffer = 1'b0;
    check("t5_valid", bif.ifmap_data_valid, 1);
    check("t5_wr_ready", bif.wr_ready, 1);
    check("t5_fill_bank", bif.fill_bank, 0);
    check_line("t5_line0", 0, pat(80));
    pulse_free();
    check("t5_valid_after_free", bif.ifmap_data_valid, 0);
    // free with nothing valid
    pulse_free();
    check("t4_free_err", bif.free_err, 1);
    tick(3);
    check("t4_free_err_hold", bif.free_err, 1);
    check("t4_valid", bif.ifmap_data_valid, 0);
    check("t4_wr_ready", bif.wr_ready, 1);
    check("t4_fill_bank", bif.fill_bank, 0);
    bif.start = 1'b1;
    bif.wr_valid = 1'b1;
    bif.wr_data = pat(255);
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.wr_valid = 1'b0;
    check("t4_start_clear", bif.free_err, 0);
    // full batch after start (start-cycle write must not shift it), then reset mid-fill
    exp_q.push_back(mk(64, 35));
    stream(64, 35, 0);
    check("t6_valid", bif.ifmap_data_valid, 1);
    stream(128, 20, 0);
    check("t6_fill_bank_pre", bif.fill_bank, 1);
    bif.wr_valid = 1'b1;
    bif.wr_data = pat(148);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", bif.ifmap_data_valid, 0);
    check("t6_rst_wr_ready", bif.wr_ready, 1);
    check("t6_rst_fill_bank", bif.fill_bank, 0);
    check("t6_rst_free_err", bif.free_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.wr_valid = 1'b0;
    exp_q.push_back(mk(16, 35));
    stream(16, 35, 0);
    check("t6_fresh_valid", bif.ifmap_data_valid, 1);
    check("t6_fresh_fill_bank", bif.fill_bank, 1);
    check_line("t6_fresh_line34", 34, pat(50));
    tick(3);
    check("queue_empty", exp_q.size(), 0);
    check("batches_seen", pops, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
